// File: rtl/mfp_pmod_als_spi_receiver.sv
// mfp_pmod_als_spi_receiver: SPI master that reads the PmodALS light sensor into an 8-bit value
module mfp_pmod_als_spi_receiver #(
  parameter int CLK_DIV_HALF = 4,
  parameter int GAP_SCK = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  output logic       cs,
  output logic       sck,
  input  logic       sdo,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       busy
);
  localparam int DW = CLK_DIV_HALF > 1 ? $clog2(CLK_DIV_HALF) : 1;
  localparam int GW = $clog2(GAP_SCK + 1);
  typedef enum logic [1:0] {GAP, FRAME, DONE} state_t;
  state_t state, state_nx;
  logic [DW-1:0] div, div_nx;
  logic [GW-1:0] gap, gap_nx, gap_inc;
  logic [3:0] bits, bits_nx;
  logic [11:0] shift, shift_nx;
  logic [7:0] value_nx;
  logic cs_nx, sck_nx, busy_nx, valid_nx, tick, rise;
  always_comb begin
    tick = div == DW'(CLK_DIV_HALF - 1);
    rise = tick && !sck;
    div_nx = tick ? '0 : div + 1'b1;
    sck_nx = sck ^ tick;
    gap_inc = gap == GW'(GAP_SCK) ? gap : gap + 1'b1;
    state_nx = state;
    cs_nx = cs;
    busy_nx = busy;
    gap_nx = gap;
    bits_nx = bits;
    shift_nx = shift;
    value_nx = value;
    valid_nx = 1'b0;
    case (state)
      GAP: if (rise) begin
        gap_nx = gap_inc;
        if (gap_inc == GW'(GAP_SCK) && enable) begin
          cs_nx = 1'b0;
          busy_nx = 1'b1;
          bits_nx = '0;
          gap_nx = '0;
          state_nx = FRAME;
        end
      end
      FRAME: if (rise) begin
        // only the low 12 bits are kept: bits above [11:4] are discarded anyway
        shift_nx = {shift[10:0], sdo};
        bits_nx = bits + 1'b1;
        if (bits == 4'd15) begin
          cs_nx = 1'b1;
          busy_nx = 1'b0;
          state_nx = DONE;
        end
      end
      default: begin
        value_nx = shift[11:4];
        valid_nx = 1'b1;
        gap_nx = '0;
        state_nx = GAP;
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= GAP;
      div <= '0;
      gap <= '0;
      bits <= '0;
      shift <= '0;
      cs <= 1'b1;
      sck <= 1'b1;
      busy <= 1'b0;
      value <= 8'h00;
      value_valid <= 1'b0;
    end else begin
      state <= state_nx;
      div <= div_nx;
      gap <= gap_nx;
      bits <= bits_nx;
      shift <= shift_nx;
      cs <= cs_nx;
      sck <= sck_nx;
      busy <= busy_nx;
      value <= value_nx;
      value_valid <= valid_nx;
    end
endmodule

// File: tb/tb_mfp_pmod_als_spi_receiver.sv
// tb_mfp_pmod_als_spi_receiver: timing and data checks against a sensor stub and frame-level arithmetic
module tb_mfp_pmod_als_spi_receiver;
  logic clock = 0, reset_n = 0, enable = 0, sdo = 0, cs, sck, value_valid, busy;
  logic [7:0] value;
  logic reset_n_b = 0, sdo_b = 0, cs_b, sck_b, value_valid_b, busy_b;
  logic [7:0] value_b;
  logic [7:0] val_a = 0, junk_a = 0, val_b = 0, junk_b = 0;
  logic [15:0] sh_a = 0, sh_b = 0;
  logic p_cs = 1, p_sck = 1, p_vv = 0;
  int cyc = 0, n_tests = 0, n_fail = 0, busy_err = 0, vv_double = 0, base = 0;
  int cs_fall[$], cs_rise[$], vv_cyc[$], vv_val[$], sck_rise[$];

  always #5 clock = ~clock;

  mfp_pmod_als_spi_receiver dut_a (
    .clock(clock), .reset_n(reset_n), .enable(enable), .cs(cs), .sck(sck),
    .sdo(sdo), .value(value), .value_valid(value_valid), .busy(busy)
  );

  mfp_pmod_als_spi_receiver #(.CLK_DIV_HALF(1), .GAP_SCK(1)) dut_b (
    .clock(clock), .reset_n(reset_n_b), .enable(1'b1), .cs(cs_b), .sck(sck_b),
    .sdo(sdo_b), .value(value_b), .value_valid(value_valid_b), .busy(busy_b)
  );

  // sensor stubs: reload on falling sck with cs high, otherwise drive the next bit MSB first
  always @(negedge sck)
    if (cs) sh_a <= {junk_a[7:4], val_a, junk_a[3:0]};
    else begin sdo <= sh_a[15]; sh_a <= {sh_a[14:0], 1'b0}; end

  always @(negedge sck_b)
    if (cs_b) sh_b <= {junk_b[7:4], val_b, junk_b[3:0]};
    else begin sdo_b <= sh_b[15]; sh_b <= {sh_b[14:0], 1'b0}; end

  always @(posedge clock) cyc <= reset_n ? cyc + 1 : 0;

  always @(negedge clock) begin
    if (p_cs && !cs) cs_fall.push_back(cyc);
    if (!p_cs && cs) cs_rise.push_back(cyc);
    if (!p_sck && sck) sck_rise.push_back(cyc);
    if (value_valid) begin vv_cyc.push_back(cyc); vv_val.push_back(int'(value)); end
    if (value_valid && p_vv) vv_double++;
    if (busy !== !cs) busy_err++;
    p_cs <= cs;
    p_sck <= sck;
    p_vv <= value_valid;
  end

  function automatic int at(input int q[$], input int i);
    return i < q.size() ? q[i] : -1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic clear();
    cs_fall.delete(); cs_rise.delete(); vv_cyc.delete(); vv_val.delete(); sck_rise.delete();
    busy_err = 0;
    vv_double = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; enable = 1; val_a = 8'hAB; junk_a = 8'($urandom);
    step(3);
    n_tests++; if (cs !== 1'b1) begin n_fail++; $display("FAIL reset_cs: got %b want 1", cs); end
    n_tests++; if (sck !== 1'b1) begin n_fail++; $display("FAIL reset_sck: got %b want 1", sck); end
    n_tests++; if (value !== 8'h00) begin n_fail++; $display("FAIL reset_value: got %h want 00", value); end
    n_tests++; if (value_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", value_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_first_frame();
    clear();
    reset_n = 1;
    step(170);
    n_tests++; if (at(cs_fall, 0) != 32) begin n_fail++; $display("FAIL first_cs_fall: got %0d want 32", at(cs_fall, 0)); end
    n_tests++; if (at(cs_rise, 0) != 160) begin n_fail++; $display("FAIL first_cs_rise: got %0d want 160", at(cs_rise, 0)); end
    n_tests++; if (at(vv_cyc, 0) != 161 || vv_cyc.size() != 1) begin n_fail++; $display("FAIL first_valid: got cycle %0d count %0d want 161 count 1", at(vv_cyc, 0), vv_cyc.size()); end
    n_tests++; if (at(vv_val, 0) != 'hAB) begin n_fail++; $display("FAIL first_value: got %0h want ab", at(vv_val, 0)); end
    n_tests++; if (value !== 8'hAB) begin n_fail++; $display("FAIL first_value_hold: got %h want ab", value); end
    // sample rises are those seen while cs was already low
    base = 0;
    foreach (sck_rise[k]) if (sck_rise[k] > 32 && sck_rise[k] <= 160) base++;
    n_tests++; if (base != 16) begin n_fail++; $display("FAIL first_sample_rises: got %0d want 16", base); end
    n_tests++; if (busy_err != 0) begin n_fail++; $display("FAIL first_busy: got %0d mismatched cycles want 0", busy_err); end
  endtask

  task automatic test_continuous();
    int bad;
    clear();
    val_a = 8'($urandom);
    junk_a = 8'($urandom);
    step(800);
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (at(vv_cyc, k) != 321 + 160 * k) begin n_fail++; $display("FAIL cont_valid_%0d: got %0d want %0d", k, at(vv_cyc, k), 321 + 160 * k); end
      n_tests++; if (at(vv_val, k) != int'(val_a)) begin n_fail++; $display("FAIL cont_value_%0d: got %0h want %0h", k, at(vv_val, k), val_a); end
      n_tests++; if (at(cs_rise, k) - at(cs_fall, k) != 128) begin n_fail++; $display("FAIL cont_window_%0d: got %0d want 128", k, at(cs_rise, k) - at(cs_fall, k)); end
    end
    bad = 0;
    for (int k = 1; k < sck_rise.size(); k++) if (sck_rise[k] - sck_rise[k-1] != 8) bad++;
    n_tests++; if (bad != 0 || sck_rise.size() != 100) begin n_fail++; $display("FAIL cont_sck_period: got %0d bad periods over %0d rises want 0 over 100", bad, sck_rise.size()); end
    n_tests++; if (vv_double != 0) begin n_fail++; $display("FAIL cont_valid_double: got %0d want 0", vv_double); end
    n_tests++; if (busy_err != 0) begin n_fail++; $display("FAIL cont_busy: got %0d want 0", busy_err); end
  endtask

  task automatic test_enable_low();
    reset_n = 0; enable = 0;
    val_a = 8'($urandom_range(1, 255));
    step(3);
    clear();
    reset_n = 1;
    step(500);
    n_tests++; if (cs_fall.size() != 0) begin n_fail++; $display("FAIL idle_cs: got %0d frames want 0", cs_fall.size()); end
    n_tests++; if (vv_cyc.size() != 0) begin n_fail++; $display("FAIL idle_valid: got %0d pulses want 0", vv_cyc.size()); end
    n_tests++; if (value !== 8'h00) begin n_fail++; $display("FAIL idle_value: got %h want 00", value); end
    n_tests++; if (sck_rise.size() != 62) begin n_fail++; $display("FAIL idle_sck: got %0d rises want 62", sck_rise.size()); end
    enable = 1;
    base = (cyc / 8 + 1) * 8;
    step(8);
    n_tests++; if (at(cs_fall, 0) != base) begin n_fail++; $display("FAIL idle_start: got %0d want %0d", at(cs_fall, 0), base); end
  endtask

  task automatic test_enable_drop();
    clear();
    step(base + 40 - cyc);
    enable = 0;
    step(400);
    n_tests++; if (at(cs_rise, 0) != base + 128) begin n_fail++; $display("FAIL drop_cs_rise: got %0d want %0d", at(cs_rise, 0), base + 128); end
    n_tests++; if (at(vv_cyc, 0) != base + 129 || vv_cyc.size() != 1) begin n_fail++; $display("FAIL drop_valid: got %0d count %0d want %0d count 1", at(vv_cyc, 0), vv_cyc.size(), base + 129); end
    n_tests++; if (at(vv_val, 0) != int'(val_a)) begin n_fail++; $display("FAIL drop_value: got %0h want %0h", at(vv_val, 0), val_a); end
    n_tests++; if (cs_fall.size() != 0) begin n_fail++; $display("FAIL drop_no_frame: got %0d frames want 0", cs_fall.size()); end
    enable = 1;
    base = (cyc / 8 + 1) * 8;
    step(10);
    n_tests++; if (at(cs_fall, 0) != base) begin n_fail++; $display("FAIL drop_restart: got %0d want %0d", at(cs_fall, 0), base); end
  endtask

  task automatic test_reset_mid();
    step(base + 66 - cyc);
    clear();
    reset_n = 0;
    #1;
    n_tests++; if (cs !== 1'b1) begin n_fail++; $display("FAIL abort_cs: got %b want 1", cs); end
    n_tests++; if (sck !== 1'b1) begin n_fail++; $display("FAIL abort_sck: got %b want 1", sck); end
    n_tests++; if (value !== 8'h00) begin n_fail++; $display("FAIL abort_value: got %h want 00", value); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    step(3);
    n_tests++; if (vv_cyc.size() != 0) begin n_fail++; $display("FAIL abort_valid: got %0d pulses want 0", vv_cyc.size()); end
    val_a = 8'($urandom);
    junk_a = 8'($urandom);
    reset_n = 1;
    step(170);
    n_tests++; if (at(cs_fall, 0) != 32) begin n_fail++; $display("FAIL abort_restart_cs: got %0d want 32", at(cs_fall, 0)); end
    n_tests++; if (at(vv_cyc, 0) != 161) begin n_fail++; $display("FAIL abort_restart_valid: got %0d want 161", at(vv_cyc, 0)); end
    n_tests++; if (at(vv_val, 0) != int'(val_a)) begin n_fail++; $display("FAIL abort_restart_value: got %0h want %0h", at(vv_val, 0), val_a); end
  endtask

  task automatic test_fast();
    int falls[$], vc[$], vv[$];
    logic pc;
    pc = 1'b1;
    val_b = 8'($urandom);
    junk_b = 8'($urandom);
    reset_n_b = 1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clock);
      #1;
      if (pc && !cs_b) falls.push_back(i);
      if (value_valid_b) begin vc.push_back(i); vv.push_back(int'(value_b)); end
      pc = cs_b;
    end
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (at(falls, k) != 2 + 34 * k) begin n_fail++; $display("FAIL fast_cs_fall_%0d: got %0d want %0d", k, at(falls, k), 2 + 34 * k); end
      n_tests++; if (at(vc, k) != 35 + 34 * k) begin n_fail++; $display("FAIL fast_valid_%0d: got %0d want %0d", k, at(vc, k), 35 + 34 * k); end
      n_tests++; if (at(vv, k) != int'(val_b)) begin n_fail++; $display("FAIL fast_value_%0d: got %0h want %0h", k, at(vv, k), val_b); end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_continuous();
    test_enable_low();
    test_enable_drop();
    test_reset_mid();
    test_fast();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mfp_pmod_als_spi_receiver.md
Name: mfp_pmod_als_spi_receiver

Overview:
- SPI master that reads the PmodALS ambient light sensor and produces an 8-bit light value.
- Sits between the light-sensor pins (SPI_CS, SPI_SCK, SPI_SDO) and the AHB-Lite GPIO read mux, under MFP_DEMO_LIGHT_SENSOR.
- Runs frames back-to-back while enabled. Each frame is 16 sck periods with cs low; bits [11:4] of the frame are the sample.
- The existing pmod_als_spi_stub in the system testbench is the sensor model. That stub shifts on falling sck and reloads its packet on falling sck while cs is high.

Parameters:
- CLK_DIV_HALF, 4: system clocks per sck half-period; legal range ≥1. sck frequency = clock / (2*CLK_DIV_HALF).
- GAP_SCK, 4: sck rising events counted with cs high between frames; legal range ≥1.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  allows a new frame to start; sampled only at frame start.
- cs  output  1  SPI chip select, active low.
- sck  output  1  SPI clock, free-running.
- sdo  input  1  SPI serial data from the sensor.
- value  output  8  last completed sample.
- value_valid  output  1  one-clock pulse when value updates.
- busy  output  1  high while cs is low.

Behaviour:
- Reset values (async on reset_n=0, held until release):
  - cs=1, sck=1, value=8'h00, value_valid=0, busy=0.
  - Divider count=0, gap count=0, bit count=0, shift register=0, state=GAP.
- sck generator:
  - Divider counts 0..CLK_DIV_HALF-1. At the terminal count a "tick" occurs, the divider wraps to 0 and sck toggles.
  - A tick with sck=0 is a rise event; a tick with sck=1 is a fall event.
  - sck toggles continuously in every state, so the sensor sees falling edges with cs high and reloads its packet.
- State GAP (cs=1):
  - Each rise event increments the gap count, saturating at GAP_SCK.
  - At a rise event where the incremented count reaches GAP_SCK and enable=1: cs<=0, busy<=1, bit count<=0, gap count<=0, go to FRAME.
  - If enable=0, stay in GAP with the count saturated. The frame starts on the first rise event with enable=1.
- State FRAME (cs=0):
  - cs falls together with sck rising. The following fall event lets the sensor drive bit 15.
  - Each later rise event shifts sdo into the shift register, MSB first, and increments the bit count.
  - On the 16th sample rise event: cs<=1, busy<=0, go to DONE.
- State DONE (one clock):
  - value <= shift[11:4], value_valid<=1 for exactly this one clock, then go to GAP with gap count=0.
- Frame period at steady state: (16+GAP_SCK)*2*CLK_DIV_HALF clocks.
- Boundary rules:
  - enable falling mid-frame does not abort; the frame completes and value updates.
  - enable is not re-examined until the next GAP exit.
  - Bits outside [11:4] are discarded and never checked.
  - value holds between updates.
  - value_valid is never high for two consecutive clocks.
  - reset_n low mid-frame: cs goes high and sck goes to 1 immediately (asynchronously), no value_valid is produced, and the partial frame is lost.
  - After reset release the sequence restarts from GAP.
  - With CLK_DIV_HALF=1, a tick occurs every clock and all rules still apply.

Test Plan:
- Defaults, stub value 8'hAB, enable=1 from reset:
  - cs falls on the 32nd posedge after reset release; 16 sck rises sampled.
  - cs rises on posedge 160; value_valid pulses on posedge 161 with value=8'hAB; busy high exactly during cs low.
- Continuous run, 5 frames: value_valid pulses every 160 clocks, value stays 8'hAB, each cs-low window is exactly 128 clocks, sck period is 8 clocks throughout.
- enable=0 from reset for 500 clocks:
  - cs stays 1, sck keeps toggling, value stays 8'h00, no value_valid.
  - Raising enable starts a frame with cs low on the next rise event.
- enable dropped 40 clocks into a frame: that frame completes with value=8'hAB; no further cs-low until enable returns.
- reset_n pulsed low during bit 8 of a frame:
  - cs=1 and sck=1 immediately, value=8'h00, no valid pulse.
  - After release, the first frame completes normally with value 8'hAB.
- Stub value 8'h5A with CLK_DIV_HALF=1 and GAP_SCK=1: value=8'h5A; frame period is 34 clocks.
